// File: rtl/branch_redirect_unit_if.sv
// rtl/branch_redirect_unit_if.sv - EX-stage branch/redirect signal bundle
//
// Groups every non-clock/reset signal of branch_redirect_unit.
//   master : EX stage / calculator side (drives EX_*, STALL, BRANCH_TAKEN)
//   slave  : branch_redirect_unit (drives BRANCH_TYPE_OUT, REDIRECT*, FLUSH_*,
//            I_FLAG, RAS_OVERFLOW, RAS_UNDERFLOW)
// Optional macro INT_VECTOR_EN adds INT_REQ and INT_RET_PC.
interface branch_redirect_unit_if #(
  parameter int PC_WIDTH = 10
);
  logic                STALL;
  logic                EX_VALID;
  logic [3:0]          EX_BRANCH_TYPE;
  logic [PC_WIDTH-1:0] EX_PC;
  logic [PC_WIDTH-1:0] EX_IMM_ADDR;
  logic [3:0]          BRANCH_TYPE_OUT;
  logic                BRANCH_TAKEN;
  logic                REDIRECT;
  logic [PC_WIDTH-1:0] REDIRECT_PC;
  logic                FLUSH_IF;
  logic                FLUSH_ID;
  logic                I_FLAG;
  logic                RAS_OVERFLOW;
  logic                RAS_UNDERFLOW;
`ifdef INT_VECTOR_EN
  logic                INT_REQ;
  logic [PC_WIDTH-1:0] INT_RET_PC;

  modport master (
    output STALL, EX_VALID, EX_BRANCH_TYPE, EX_PC, EX_IMM_ADDR, BRANCH_TAKEN,
           INT_REQ, INT_RET_PC,
    input  BRANCH_TYPE_OUT, REDIRECT, REDIRECT_PC, FLUSH_IF, FLUSH_ID, I_FLAG,
           RAS_OVERFLOW, RAS_UNDERFLOW
  );
  modport slave (
    input  STALL, EX_VALID, EX_BRANCH_TYPE, EX_PC, EX_IMM_ADDR, BRANCH_TAKEN,
           INT_REQ, INT_RET_PC,
    output BRANCH_TYPE_OUT, REDIRECT, REDIRECT_PC, FLUSH_IF, FLUSH_ID, I_FLAG,
           RAS_OVERFLOW, RAS_UNDERFLOW
  );
`else
  modport master (
    output STALL, EX_VALID, EX_BRANCH_TYPE, EX_PC, EX_IMM_ADDR, BRANCH_TAKEN,
    input  BRANCH_TYPE_OUT, REDIRECT, REDIRECT_PC, FLUSH_IF, FLUSH_ID, I_FLAG,
           RAS_OVERFLOW, RAS_UNDERFLOW
  );
  modport slave (
    input  STALL, EX_VALID, EX_BRANCH_TYPE, EX_PC, EX_IMM_ADDR, BRANCH_TAKEN,
    output BRANCH_TYPE_OUT, REDIRECT, REDIRECT_PC, FLUSH_IF, FLUSH_ID, I_FLAG,
           RAS_OVERFLOW, RAS_UNDERFLOW
  );
`endif
endinterface

// File: rtl/branch_redirect_unit.sv
// rtl/branch_redirect_unit.sv - EX-stage control flow / PC redirect unit
//
// Ports:
//   CLK  : system clock, rising edge
//   RST  : asynchronous active-high reset
//   bus  : branch_redirect_unit_if.slave - EX-stage branch inputs, calculator
//          handshake, redirect/flush outputs, I_FLAG, sticky RAS error flags
// Optional macro INT_VECTOR_EN: interrupt vectoring to the all-ones PC.
module branch_redirect_unit #(
  parameter int PC_WIDTH     = 10,
  parameter int RAS_DEPTH    = 8,
  parameter int FLUSH_CYCLES = 2
) (
  input logic                    CLK,
  input logic                    RST,
  branch_redirect_unit_if.slave  bus
);
  localparam int              PW         = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int              CW         = $clog2(RAS_DEPTH + 1);
  localparam logic [CW-1:0]   RAS_FULL   = CW'(RAS_DEPTH);
  localparam logic [CW-1:0]   CNT_ONE    = CW'(1);
  localparam logic [PW-1:0]   PTR_ONE    = PW'(1);
  localparam logic [1:0]      FLUSH_LOAD = 2'(FLUSH_CYCLES - 1);
  localparam logic [PC_WIDTH-1:0] PC_ONE = PC_WIDTH'(1);

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t              state_q, state_d;
  logic [1:0]          fcnt_q, fcnt_d;
  logic                redirect_q;
  logic [PC_WIDTH-1:0] redirect_pc_q, redirect_pc_d;
  logic                i_flag_q, i_flag_d;
  logic                ovf_q, ovf_d, unf_q, unf_d;
  logic [PC_WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [PW-1:0]       ptr_q, ptr_d;   // next free slot
  logic [CW-1:0]       cnt_q, cnt_d;

  logic                accept, taken, fire, push;
  logic [PC_WIDTH-1:0] push_val, tos;
  logic [3:0]          btype;

  assign btype  = bus.EX_BRANCH_TYPE;
  assign accept = bus.EX_VALID && !bus.STALL && (state_q == IDLE);
  // Types outside 1..9 are treated as "no branch" even if the calculator says taken.
  assign taken  = accept && bus.BRANCH_TAKEN && (btype >= 4'd1) && (btype <= 4'd9);
  assign tos    = ras_mem[ptr_q - PTR_ONE];

  assign bus.BRANCH_TYPE_OUT = accept ? btype : 4'd0;
  assign bus.REDIRECT        = redirect_q;
  assign bus.REDIRECT_PC     = redirect_pc_q;
  assign bus.FLUSH_IF        = (state_q == FLUSH);
  assign bus.FLUSH_ID        = (state_q == FLUSH);
  assign bus.I_FLAG          = i_flag_q;
  assign bus.RAS_OVERFLOW    = ovf_q;
  assign bus.RAS_UNDERFLOW   = unf_q;

  always_comb begin
    state_d       = state_q;
    fcnt_d        = fcnt_q;
    fire          = 1'b0;
    push          = 1'b0;
    push_val      = '0;
    redirect_pc_d = redirect_pc_q;
    i_flag_d      = i_flag_q;
    ovf_d         = ovf_q;
    unf_d         = unf_q;
    ptr_d         = ptr_q;
    cnt_d         = cnt_q;

    case (state_q)
      IDLE: begin
        if (taken) begin
          fire = 1'b1;
          if (btype <= 4'd5) begin
            redirect_pc_d = bus.EX_IMM_ADDR;
          end else if (btype == 4'd6) begin
            redirect_pc_d = bus.EX_IMM_ADDR;
            push          = 1'b1;
            push_val      = bus.EX_PC + PC_ONE;
          end else begin
            // RET/RETID/RETIE: pop; an empty stack still redirects, to 0.
            if (cnt_q == '0) begin
              redirect_pc_d = '0;
              unf_d         = 1'b1;
            end else begin
              redirect_pc_d = tos;
              ptr_d         = ptr_q - PTR_ONE;
              cnt_d         = cnt_q - CNT_ONE;
            end
            if (btype == 4'd8)      i_flag_d = 1'b0;
            else if (btype == 4'd9) i_flag_d = 1'b1;
          end
        end
`ifdef INT_VECTOR_EN
        else if (!bus.STALL && i_flag_q && bus.INT_REQ) begin
          // A taken branch wins; the interrupt waits for the next idle cycle.
          fire          = 1'b1;
          push          = 1'b1;
          push_val      = bus.INT_RET_PC;
          i_flag_d      = 1'b0;
          redirect_pc_d = '1;
        end
`endif
        if (fire) begin
          state_d = FLUSH;
          fcnt_d  = FLUSH_LOAD;
        end
      end
      FLUSH: begin
        if (!bus.STALL) begin
          if (fcnt_q == 2'd0) state_d = IDLE;
          else                fcnt_d  = fcnt_q - 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Full stack: the write pointer sits on the oldest entry, so a push
    // overwrites it and the count saturates.
    if (push) begin
      ptr_d = ptr_q + PTR_ONE;
      if (cnt_q == RAS_FULL) ovf_d = 1'b1;
      else                   cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q       <= IDLE;
      fcnt_q        <= 2'd0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      i_flag_q      <= 1'b0;
      ovf_q         <= 1'b0;
      unf_q         <= 1'b0;
      ptr_q         <= '0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      fcnt_q        <= fcnt_d;
      // fire is never set while stalled, so the strobe cannot stretch.
      redirect_q    <= fire;
      redirect_pc_q <= redirect_pc_d;
      i_flag_q      <= i_flag_d;
      ovf_q         <= ovf_d;
      unf_q         <= unf_d;
      ptr_q         <= ptr_d;
      cnt_q         <= cnt_d;
    end
  end

  // Stack storage needs no reset: count/pointer define which entries are live.
  always_ff @(posedge CLK) begin
    if (push && !RST) ras_mem[ptr_q] <= push_val;
  end
endmodule

// File: tb/tb_branch_redirect_unit.sv
// tb/tb_branch_redirect_unit.sv - directed self-checking bench for branch_redirect_unit
module tb_branch_redirect_unit;
  logic clk;
  logic rst;
  int   pass_cnt;
  int   total_cnt;

  branch_redirect_unit_if #(.PC_WIDTH(10)) bus ();

  branch_redirect_unit #(
    .PC_WIDTH(10), .RAS_DEPTH(8), .FLUSH_CYCLES(2)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.STALL          = 1'b0;
    bus.EX_VALID       = 1'b0;
    bus.EX_BRANCH_TYPE = 4'd0;
    bus.EX_PC          = '0;
    bus.EX_IMM_ADDR    = '0;
    bus.BRANCH_TAKEN   = 1'b0;
`ifdef INT_VECTOR_EN
    bus.INT_REQ        = 1'b0;
    bus.INT_RET_PC     = '0;
`endif
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // Presents one instruction for a single cycle; returns in cycle N+1.
  task automatic do_branch(input logic [3:0] t, input logic [9:0] pc,
                           input logic [9:0] imm, input logic tk);
    bus.EX_VALID = 1'b1; bus.EX_BRANCH_TYPE = t; bus.EX_PC = pc;
    bus.EX_IMM_ADDR = imm; bus.BRANCH_TAKEN = tk;
    step();
    bus.EX_VALID = 1'b0; bus.EX_BRANCH_TYPE = 4'd0; bus.BRANCH_TAKEN = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    step();
    total_cnt++; if ({bus.REDIRECT, bus.FLUSH_IF, bus.FLUSH_ID, bus.I_FLAG, bus.RAS_OVERFLOW, bus.RAS_UNDERFLOW} !== 6'b0) $display("FAIL reset_flags: got %b want 000000", {bus.REDIRECT, bus.FLUSH_IF, bus.FLUSH_ID, bus.I_FLAG, bus.RAS_OVERFLOW, bus.RAS_UNDERFLOW}); else pass_cnt++;
    total_cnt++; if (bus.REDIRECT_PC !== 10'h000) $display("FAIL reset_pc: got %h want 000", bus.REDIRECT_PC); else pass_cnt++;
    total_cnt++; if (bus.BRANCH_TYPE_OUT !== 4'd0) $display("FAIL reset_bto: got %0d want 0", bus.BRANCH_TYPE_OUT); else pass_cnt++;
    rst = 1'b0;
    step();
  endtask

  task automatic test_breq();
    bus.EX_VALID = 1'b1; bus.EX_BRANCH_TYPE = 4'd3; bus.EX_PC = 10'h010;
    bus.EX_IMM_ADDR = 10'h120; bus.BRANCH_TAKEN = 1'b1;
    #1;
    total_cnt++; if (bus.BRANCH_TYPE_OUT !== 4'd3) $display("FAIL breq_bto_accept: got %0d want 3", bus.BRANCH_TYPE_OUT); else pass_cnt++;
    step();  // N+1; keep a valid taken BREQ present to prove it is squashed
    bus.EX_IMM_ADDR = 10'h333;
    total_cnt++; if (bus.REDIRECT !== 1'b1) $display("FAIL breq_redirect: got %b want 1", bus.REDIRECT); else pass_cnt++;
    total_cnt++; if (bus.REDIRECT_PC !== 10'h120) $display("FAIL breq_pc: got %h want 120", bus.REDIRECT_PC); else pass_cnt++;
    total_cnt++; if ({bus.FLUSH_IF, bus.FLUSH_ID} !== 2'b11) $display("FAIL breq_flush_n1: got %b want 11", {bus.FLUSH_IF, bus.FLUSH_ID}); else pass_cnt++;
    total_cnt++; if (bus.BRANCH_TYPE_OUT !== 4'd0) $display("FAIL breq_squash_bto: got %0d want 0", bus.BRANCH_TYPE_OUT); else pass_cnt++;
    step();  // N+2
    total_cnt++; if (bus.REDIRECT !== 1'b0) $display("FAIL breq_redirect_n2: got %b want 0", bus.REDIRECT); else pass_cnt++;
    total_cnt++; if ({bus.FLUSH_IF, bus.FLUSH_ID} !== 2'b11) $display("FAIL breq_flush_n2: got %b want 11", {bus.FLUSH_IF, bus.FLUSH_ID}); else pass_cnt++;
    bus.EX_VALID = 1'b0; bus.BRANCH_TAKEN = 1'b0;
    step();  // N+3
    total_cnt++; if ({bus.REDIRECT, bus.FLUSH_IF, bus.FLUSH_ID} !== 3'b000) $display("FAIL breq_end: got %b want 000", {bus.REDIRECT, bus.FLUSH_IF, bus.FLUSH_ID}); else pass_cnt++;
    total_cnt++; if (bus.REDIRECT_PC !== 10'h120) $display("FAIL breq_pc_hold: got %h want 120", bus.REDIRECT_PC); else pass_cnt++;
  endtask

  task automatic test_not_taken();
    do_branch(4'd5, 10'h010, 10'h2AA, 1'b0);
    total_cnt++; if ({bus.REDIRECT, bus.FLUSH_IF} !== 2'b00) $display("FAIL nt_brne: got %b want 00", {bus.REDIRECT, bus.FLUSH_IF}); else pass_cnt++;
    do_branch(4'd0, 10'h010, 10'h2BB, 1'b1);
    total_cnt++; if ({bus.REDIRECT, bus.FLUSH_IF} !== 2'b00) $display("FAIL nt_type0: got %b want 00", {bus.REDIRECT, bus.FLUSH_IF}); else pass_cnt++;
    total_cnt++; if (bus.REDIRECT_PC !== 10'h120) $display("FAIL nt_pc_hold: got %h want 120", bus.REDIRECT_PC); else pass_cnt++;
    do_branch(4'd7, 10'h010, 10'h000, 1'b0);  // RET not taken: no pop, no flags
    total_cnt++; if ({bus.REDIRECT, bus.RAS_UNDERFLOW} !== 2'b00) $display("FAIL nt_ret: got %b want 00", {bus.REDIRECT, bus.RAS_UNDERFLOW}); else pass_cnt++;
  endtask

  task automatic test_call_ret();
    apply_reset();
    do_branch(4'd6, 10'h050, 10'h200, 1'b1);
    total_cnt++; if ({bus.REDIRECT, bus.REDIRECT_PC} !== {1'b1, 10'h200}) $display("FAIL call_redirect: got %b/%h want 1/200", bus.REDIRECT, bus.REDIRECT_PC); else pass_cnt++;
    step(); step();
    do_branch(4'd7, 10'h200, 10'h000, 1'b1);
    total_cnt++; if ({bus.REDIRECT, bus.REDIRECT_PC} !== {1'b1, 10'h051}) $display("FAIL ret_redirect: got %b/%h want 1/051", bus.REDIRECT, bus.REDIRECT_PC); else pass_cnt++;
    total_cnt++; if (bus.RAS_UNDERFLOW !== 1'b0) $display("FAIL ret_no_unf: got %b want 0", bus.RAS_UNDERFLOW); else pass_cnt++;
    step(); step();
    do_branch(4'd7, 10'h051, 10'h000, 1'b1);  // stack should now be empty
    total_cnt++; if ({bus.REDIRECT_PC, bus.RAS_UNDERFLOW} !== {10'h000, 1'b1}) $display("FAIL ret_empty: got %h/%b want 000/1", bus.REDIRECT_PC, bus.RAS_UNDERFLOW); else pass_cnt++;
    step(); step();
    do_branch(4'd6, 10'h3FF, 10'h010, 1'b1);  // EX_PC+1 wraps to 0
    step(); step();
    do_branch(4'd7, 10'h010, 10'h000, 1'b1);
    total_cnt++; if (bus.REDIRECT_PC !== 10'h000) $display("FAIL call_wrap: got %h want 000", bus.REDIRECT_PC); else pass_cnt++;
    step(); step();
  endtask

  task automatic test_iflag();
    apply_reset();
    do_branch(4'd6, 10'h010, 10'h100, 1'b1); step(); step();
    do_branch(4'd6, 10'h020, 10'h180, 1'b1); step(); step();
    total_cnt++; if (bus.I_FLAG !== 1'b0) $display("FAIL iflag_pre: got %b want 0", bus.I_FLAG); else pass_cnt++;
    do_branch(4'd9, 10'h180, 10'h000, 1'b1);
    total_cnt++; if ({bus.I_FLAG, bus.REDIRECT_PC} !== {1'b1, 10'h021}) $display("FAIL retie: got %b/%h want 1/021", bus.I_FLAG, bus.REDIRECT_PC); else pass_cnt++;
    bus.EX_VALID = 1'b1; bus.EX_BRANCH_TYPE = 4'd8; bus.BRANCH_TAKEN = 1'b1;  // squashed RETID
    #1;
    total_cnt++; if (bus.BRANCH_TYPE_OUT !== 4'd0) $display("FAIL retid_squash_bto: got %0d want 0", bus.BRANCH_TYPE_OUT); else pass_cnt++;
    step();
    bus.EX_VALID = 1'b0; bus.EX_BRANCH_TYPE = 4'd0; bus.BRANCH_TAKEN = 1'b0;
    total_cnt++; if (bus.I_FLAG !== 1'b1) $display("FAIL retid_squash_iflag: got %b want 1", bus.I_FLAG); else pass_cnt++;
    step();
    do_branch(4'd8, 10'h021, 10'h000, 1'b1);
    total_cnt++; if ({bus.I_FLAG, bus.REDIRECT_PC} !== {1'b0, 10'h011}) $display("FAIL retid: got %b/%h want 0/011", bus.I_FLAG, bus.REDIRECT_PC); else pass_cnt++;
    step(); step();
  endtask

  task automatic test_stall();
    apply_reset();
    do_branch(4'd5, 10'h030, 10'h0AA, 1'b1);  // N+1
    total_cnt++; if ({bus.REDIRECT, bus.FLUSH_IF, bus.REDIRECT_PC} !== {2'b11, 10'h0AA}) $display("FAIL stall_n1: got %b%b/%h want 11/0AA", bus.REDIRECT, bus.FLUSH_IF, bus.REDIRECT_PC); else pass_cnt++;
    step();  // N+2: stall begins
    bus.STALL = 1'b1;
    total_cnt++; if ({bus.REDIRECT, bus.FLUSH_IF, bus.FLUSH_ID} !== 3'b011) $display("FAIL stall_n2: got %b want 011", {bus.REDIRECT, bus.FLUSH_IF, bus.FLUSH_ID}); else pass_cnt++;
    step();  // N+3
    total_cnt++; if ({bus.REDIRECT, bus.FLUSH_IF} !== 2'b01) $display("FAIL stall_n3: got %b want 01", {bus.REDIRECT, bus.FLUSH_IF}); else pass_cnt++;
    step();  // N+4
    total_cnt++; if ({bus.REDIRECT, bus.FLUSH_IF} !== 2'b01) $display("FAIL stall_n4: got %b want 01", {bus.REDIRECT, bus.FLUSH_IF}); else pass_cnt++;
    step();  // N+5: stall released, last unstalled flush cycle
    bus.STALL = 1'b0;
    total_cnt++; if ({bus.FLUSH_IF, bus.FLUSH_ID} !== 2'b11) $display("FAIL stall_n5: got %b want 11", {bus.FLUSH_IF, bus.FLUSH_ID}); else pass_cnt++;
    step();  // N+6
    total_cnt++; if ({bus.REDIRECT, bus.FLUSH_IF, bus.FLUSH_ID} !== 3'b000) $display("FAIL stall_n6: got %b want 000", {bus.REDIRECT, bus.FLUSH_IF, bus.FLUSH_ID}); else pass_cnt++;

    // Stall during the REDIRECT cycle itself: strobe must not stretch.
    do_branch(4'd1, 10'h031, 10'h0CC, 1'b1);
    bus.STALL = 1'b1;
    step();
    bus.STALL = 1'b0;
    total_cnt++; if ({bus.REDIRECT, bus.FLUSH_IF} !== 2'b01) $display("FAIL nostretch_n2: got %b want 01", {bus.REDIRECT, bus.FLUSH_IF}); else pass_cnt++;
    step();
    total_cnt++; if (bus.FLUSH_IF !== 1'b1) $display("FAIL nostretch_n3: got %b want 1", bus.FLUSH_IF); else pass_cnt++;
    step();
    total_cnt++; if (bus.FLUSH_IF !== 1'b0) $display("FAIL nostretch_n4: got %b want 0", bus.FLUSH_IF); else pass_cnt++;

    // Stall while idle blocks acceptance.
    bus.STALL = 1'b1; bus.EX_VALID = 1'b1; bus.EX_BRANCH_TYPE = 4'd3;
    bus.EX_IMM_ADDR = 10'h155; bus.BRANCH_TAKEN = 1'b1;
    #1;
    total_cnt++; if (bus.BRANCH_TYPE_OUT !== 4'd0) $display("FAIL stall_idle_bto: got %0d want 0", bus.BRANCH_TYPE_OUT); else pass_cnt++;
    step();
    total_cnt++; if ({bus.REDIRECT, bus.FLUSH_IF, bus.REDIRECT_PC} !== {2'b00, 10'h0CC}) $display("FAIL stall_idle: got %b%b/%h want 00/0CC", bus.REDIRECT, bus.FLUSH_IF, bus.REDIRECT_PC); else pass_cnt++;
    idle_inputs();
  endtask

  task automatic test_overflow();
    apply_reset();
    for (int i = 0; i < 9; i++) begin
      if (i == 8) begin
        total_cnt++; if (bus.RAS_OVERFLOW !== 1'b0) $display("FAIL ovf_before: got %b want 0", bus.RAS_OVERFLOW); else pass_cnt++;
      end
      do_branch(4'd6, 10'(i), 10'h300, 1'b1);
      step(); step();
    end
    total_cnt++; if (bus.RAS_OVERFLOW !== 1'b1) $display("FAIL ovf_set: got %b want 1", bus.RAS_OVERFLOW); else pass_cnt++;
    for (int k = 0; k < 8; k++) begin
      do_branch(4'd7, 10'h300, 10'h000, 1'b1);
      total_cnt++; if (bus.REDIRECT_PC !== 10'(9 - k)) $display("FAIL ovf_pop%0d: got %h want %h", k, bus.REDIRECT_PC, 10'(9 - k)); else pass_cnt++;
      step(); step();
    end
    total_cnt++; if (bus.RAS_UNDERFLOW !== 1'b0) $display("FAIL unf_before: got %b want 0", bus.RAS_UNDERFLOW); else pass_cnt++;
    do_branch(4'd7, 10'h300, 10'h000, 1'b1);
    total_cnt++; if ({bus.REDIRECT, bus.REDIRECT_PC, bus.RAS_UNDERFLOW} !== {1'b1, 10'h000, 1'b1}) $display("FAIL unf_pop9: got %b/%h/%b want 1/000/1", bus.REDIRECT, bus.REDIRECT_PC, bus.RAS_UNDERFLOW); else pass_cnt++;
    step(); step();
    total_cnt++; if ({bus.RAS_OVERFLOW, bus.RAS_UNDERFLOW} !== 2'b11) $display("FAIL sticky: got %b want 11", {bus.RAS_OVERFLOW, bus.RAS_UNDERFLOW}); else pass_cnt++;
  endtask

  task automatic test_rst_mid_flush();
    apply_reset();
    do_branch(4'd6, 10'h040, 10'h100, 1'b1);
    total_cnt++; if ({bus.REDIRECT, bus.FLUSH_IF} !== 2'b11) $display("FAIL rmf_pre: got %b want 11", {bus.REDIRECT, bus.FLUSH_IF}); else pass_cnt++;
    rst = 1'b1;
    #1;
    total_cnt++; if ({bus.REDIRECT, bus.FLUSH_IF, bus.FLUSH_ID, bus.REDIRECT_PC} !== 13'h0) $display("FAIL rmf_async: got %b%b%b/%h want 000/000", bus.REDIRECT, bus.FLUSH_IF, bus.FLUSH_ID, bus.REDIRECT_PC); else pass_cnt++;
    step();
    rst = 1'b0;
    step();
    total_cnt++; if (bus.FLUSH_IF !== 1'b0) $display("FAIL rmf_abandon: got %b want 0", bus.FLUSH_IF); else pass_cnt++;
    do_branch(4'd7, 10'h100, 10'h000, 1'b1);
    total_cnt++; if ({bus.REDIRECT, bus.REDIRECT_PC, bus.RAS_UNDERFLOW} !== {1'b1, 10'h000, 1'b1}) $display("FAIL rmf_ret: got %b/%h/%b want 1/000/1", bus.REDIRECT, bus.REDIRECT_PC, bus.RAS_UNDERFLOW); else pass_cnt++;
    step(); step();
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rst       = 1'b1;
    idle_inputs();
    test_reset();
    test_breq();
    test_not_taken();
    test_call_ret();
    test_iflag();
    test_stall();
    test_overflow();
    test_rst_mid_flush();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/branch_redirect_unit.md
Name: branch_redirect_unit

Overview:
- Execute-stage control flow unit for the RAT pipeline.
- Drives the branch type to the branch-taken calculator and consumes its taken result.
- On a taken branch, computes the redirect PC, issues the PC redirect and the IF/ID flush sequence, and manages the return address stack (CALL/RET) and the interrupt-enable flag (RETID/RETIE).

Parameters:
PC_WIDTH, 10, program counter width
RAS_DEPTH, 8, return address stack entries (power of 2)
FLUSH_CYCLES, 2, cycles FLUSH_IF/FLUSH_ID stay asserted per redirect (1..4)

Ports:
CLK  in  1  system clock, rising edge
RST  in  1  asynchronous, active-high reset
STALL  in  1  pipeline stall; freezes all state
EX_VALID  in  1  EX-stage instruction valid
EX_BRANCH_TYPE  in  4  0 none, 1 BRCC, 2 BRCS, 3 BREQ, 4 BRN, 5 BRNE, 6 CALL, 7 RET, 8 RETID, 9 RETIE
EX_PC  in  PC_WIDTH  PC of EX-stage instruction
EX_IMM_ADDR  in  PC_WIDTH  immediate branch/call target
BRANCH_TYPE_OUT  out  4  to calculator: EX_BRANCH_TYPE when accepted, else 0 (combinational)
BRANCH_TAKEN  in  1  from calculator, same cycle
REDIRECT  out  1  one-cycle PC load strobe
REDIRECT_PC  out  PC_WIDTH  new PC, valid with REDIRECT
FLUSH_IF  out  1  squash fetch stage
FLUSH_ID  out  1  squash decode stage
I_FLAG  out  1  interrupt enable
RAS_OVERFLOW  out  1  sticky: push while full
RAS_UNDERFLOW  out  1  sticky: pop while empty

Behaviour:
- Reset (async, RST=1): REDIRECT=0, REDIRECT_PC=0, FLUSH_IF=0, FLUSH_ID=0, I_FLAG=0, both sticky flags=0, RAS empty (count 0, pointer 0), FSM=IDLE.
- Accept condition: EX_VALID && !STALL && FSM==IDLE. BRANCH_TYPE_OUT=EX_BRANCH_TYPE when accepted, else 0.
- FSM states:
  - IDLE: on accept with BRANCH_TAKEN=1, go to FLUSH and load the flush counter with FLUSH_CYCLES-1.
  - FLUSH: counter decrements each unstalled cycle; return to IDLE when it reaches 0 on an unstalled cycle.
- Timing: taken branch accepted at cycle N.
  - At N+1: REDIRECT=1 for exactly one cycle, with REDIRECT_PC registered.
  - FLUSH_IF and FLUSH_ID =1 for FLUSH_CYCLES unstalled cycles, starting at N+1.
- Squashing: EX_VALID during FLUSH is not accepted. BRANCH_TYPE_OUT=0, and no RAS or I_FLAG side effects occur.
- Target selection:
  - Types 1–5: EX_IMM_ADDR.
  - Type 6 (CALL): EX_IMM_ADDR, and push EX_PC+1. Addition is mod 2^PC_WIDTH, so 0x3FF+1 wraps to 0x000.
  - Types 7–9: popped top-of-stack.
- Type 6–9 flags: the calculator always reports these taken. If BRANCH_TAKEN=0 for types 6–9, no redirect and no RAS change occur.
- I_FLAG: RETID clears it and RETIE sets it, on the accept edge.
- RAS push while full (count==RAS_DEPTH): circular overwrite of the oldest entry, count stays RAS_DEPTH, RAS_OVERFLOW set.
- RAS pop while empty: REDIRECT_PC=0, count stays 0, RAS_UNDERFLOW set, redirect still issued.
- Sticky flags clear only on RST.
- STALL=1: no accept, flush counter and all registers hold. FLUSH_IF/FLUSH_ID remain at their current value. A REDIRECT pulse already scheduled is still a single cycle (not stretched).
- Not-taken branch or type 0: no outputs change.
- RST mid-flush: immediate return to reset values; the pending flush is abandoned.

Optional Feature:
Macro INT_VECTOR_EN.
- Defined:
  - Adds inputs INT_REQ (1) and INT_RET_PC (PC_WIDTH).
  - In IDLE, !STALL, I_FLAG=1, INT_REQ=1, and no taken branch accepted that cycle, the unit:
    - pushes INT_RET_PC;
    - clears I_FLAG;
    - issues REDIRECT to all-ones (0x3FF at default width);
    - runs the normal flush sequence.
  - A taken branch in the same cycle wins; the interrupt is taken on the next eligible cycle.
- Undefined: ports absent; I_FLAG changes only via RETID/RETIE.

Test Plan:
- BREQ accepted, BRANCH_TAKEN=1, EX_IMM_ADDR=0x120 -> next cycle REDIRECT=1, REDIRECT_PC=0x120; FLUSH_IF/ID high 2 cycles; EX_VALID during flush yields BRANCH_TYPE_OUT=0.
- CALL at EX_PC=0x050 to 0x200, then RET -> first redirect 0x200; second redirect 0x051; RAS count back to 0.
- 9 CALLs (EX_PC 0x000..0x008) with RAS_DEPTH=8, then 8 RETs -> RAS_OVERFLOW=1; pops return 0x009 down to 0x002; ninth RET -> REDIRECT_PC=0, RAS_UNDERFLOW=1.
- RETIE then RETID (RAS preloaded) -> I_FLAG 0→1→0 on the accept edges.
- Taken BRNE, STALL=1 for 3 cycles starting N+2 -> FLUSH held high during the stall; total unstalled flush cycles = 2; REDIRECT a single pulse.
- RST asserted mid-flush after a CALL -> all outputs 0 asynchronously; a following RET flags underflow.
